// File: rtl/lsu_sram_master.sv
// Load/store initiator for the single-port sram responder.
// One outstanding request; aligns/extends loads, lane-shifts stores.
module lsu_sram_master #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_load,
   input  logic        req_store,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        sram_ren,
   output logic        sram_wen,
   output logic [7:0]  sram_wmask,
   output logic [31:0] sram_addr,
   output logic [31:0] sram_wdata,
   input  logic [31:0] sram_data,
   input  logic        sram_valid,
   output logic        sram_receive_valid,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_WAIT,
      WR,
      RESP
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       f3_q;
   logic [1:0]       off_q;
   logic             f3_ok;
   logic             mis;
   logic             bad;
   logic [3:0]       lane;
   logic [31:0]      w;
   logic [31:0]      ld_data;

   assign req_ready = (state == IDLE);

   // Ack in the same cycle the sram presents data, so the sram can drop it.
   assign sram_receive_valid = (state == RD_WAIT) && sram_valid;

   always_comb begin
      f3_ok = 1'b0;
      unique case (req_funct3)
         3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
         3'b100, 3'b101:         f3_ok = req_load;
         default:                f3_ok = 1'b0;
      endcase
      mis = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
            ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
      bad = (req_load == req_store) || !f3_ok || mis;
   end

   always_comb begin
      lane = 4'hF;
      case (req_funct3[1:0])
         2'b00:   lane = 4'b0001 << req_addr[1:0];
         2'b01:   lane = 4'b0011 << req_addr[1:0];
         default: lane = 4'hF;
      endcase
   end

   always_comb begin
      w       = sram_data >> {off_q, 3'b000};
      ld_data = 32'h0;
      case (f3_q)
         3'b000:  ld_data = {{24{w[7]}}, w[7:0]};
         3'b001:  ld_data = {{16{w[15]}}, w[15:0]};
         3'b010:  ld_data = w;
         3'b100:  ld_data = {24'h0, w[7:0]};
         3'b101:  ld_data = {16'h0, w[15:0]};
         default: ld_data = 32'h0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= '0;
         f3_q       <= 3'b0;
         off_q      <= 2'b0;
         sram_ren   <= 1'b0;
         sram_wen   <= 1'b0;
         sram_wmask <= 8'h0;
         sram_addr  <= 32'h0;
         sram_wdata <= 32'h0;
         resp_valid <= 1'b0;
         resp_rdata <= 32'h0;
         resp_err   <= 1'b0;
      end else begin
         sram_ren   <= 1'b0;
         sram_wen   <= 1'b0;
         sram_wmask <= 8'h0;
         unique case (state)
            IDLE: begin
               if (req_valid) begin
                  f3_q  <= req_funct3;
                  off_q <= req_addr[1:0];
                  if (bad) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= 32'h0;
                  end else begin
                     sram_addr <= {req_addr[31:2], 2'b00};
                     if (req_load) begin
                        state    <= RD_REQ;
                        sram_ren <= 1'b1;
                     end else begin
                        state      <= WR;
                        sram_wen   <= 1'b1;
                        sram_wmask <= {4'h0, lane};
                        sram_wdata <= req_wdata << {req_addr[1:0], 3'b000};
                     end
                  end
               end
            end
            RD_REQ: begin
               state <= RD_WAIT;
               cnt   <= '0;
            end
            RD_WAIT: begin
               if (sram_valid) begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b0;
                  resp_rdata <= ld_data;
               end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
                  resp_rdata <= 32'h0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            WR: begin
               state      <= RESP;
               resp_valid <= 1'b1;
               resp_err   <= 1'b0;
               resp_rdata <= 32'h0;
            end
            RESP: begin
               if (resp_ready) begin
                  state      <= IDLE;
                  resp_valid <= 1'b0;
                  resp_err   <= 1'b0;
                  resp_rdata <= 32'h0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_sram_master.sv
// Directed bench for lsu_sram_master with a transaction-level model
// and a per-cycle compare process.
module tb_lsu_sram_master;

   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_load = 1'b0;
   logic        req_store = 1'b0;
   logic [2:0]  req_funct3 = 3'b0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        sram_ren;
   logic        sram_wen;
   logic [7:0]  sram_wmask;
   logic [31:0] sram_addr;
   logic [31:0] sram_wdata;
   logic [31:0] sram_data = 32'h0;
   logic        sram_valid = 1'b0;
   logic        sram_receive_valid;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_rdata;
   logic        resp_err;

   lsu_sram_master #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
      .clk(clk),
      .rst(rst),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_load(req_load),
      .req_store(req_store),
      .req_funct3(req_funct3),
      .req_addr(req_addr),
      .req_wdata(req_wdata),
      .sram_ren(sram_ren),
      .sram_wen(sram_wen),
      .sram_wmask(sram_wmask),
      .sram_addr(sram_addr),
      .sram_wdata(sram_wdata),
      .sram_data(sram_data),
      .sram_valid(sram_valid),
      .sram_receive_valid(sram_receive_valid),
      .resp_valid(resp_valid),
      .resp_ready(resp_ready),
      .resp_rdata(resp_rdata),
      .resp_err(resp_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   typedef struct {
      bit          ld;
      bit          st;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] sdata;
      bit          to;
      int          d;
      logic [31:0] er;
      bit          ee;
      logic [7:0]  em;
      logic [31:0] ew;
   } vec_t;

   vec_t vq[$];

   function automatic int m_size(input logic [2:0] f3);
      return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
   endfunction

   function automatic bit m_err(input bit ld, input bit st,
                                input logic [2:0] f3,
                                input logic [31:0] addr);
      if (ld == st) return 1'b1;
      if (ld && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
      if (st && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b1;
      return (addr % m_size(f3)) != 0;
   endfunction

   function automatic logic [31:0] m_rdata(input logic [2:0] f3,
                                           input logic [31:0] addr,
                                           input logic [31:0] sdata);
      int          bits;
      logic [63:0] keep;
      logic [31:0] r;
      bits = 8 * m_size(f3);
      keep = (64'd1 << bits) - 64'd1;
      r    = (sdata >> (8 * (addr % 4))) & keep[31:0];
      if (!f3[2] && r[bits-1]) r = r | ~keep[31:0];
      return r;
   endfunction

   function automatic logic [7:0] m_mask(input logic [2:0] f3,
                                         input logic [31:0] addr);
      int n;
      n = m_size(f3);
      return 8'(((1 << n) - 1) << (addr % 4));
   endfunction

   bit          chk_en = 1'b0;
   bit          active = 1'b0;
   int          acc = 0;
   int          c_l = 0;
   int          c_d = 0;
   bit          c_ld = 1'b0;
   bit          c_st = 1'b0;
   bit          c_to = 1'b0;
   bit          c_err = 1'b0;
   logic [31:0] c_rdata = 32'h0;
   logic [7:0]  c_mask = 8'h0;
   logic [31:0] c_wd = 32'h0;
   logic [31:0] c_addr = 32'h0;
   int          kk;

   always @(negedge clk) begin
      if (chk_en) begin
         if (!active) begin
            chk("idle_ren", 32'(sram_ren), 32'h0);
            chk("idle_wen", 32'(sram_wen), 32'h0);
            chk("idle_wmask", 32'(sram_wmask), 32'h0);
            chk("idle_resp_valid", 32'(resp_valid), 32'h0);
            chk("idle_req_ready", 32'(req_ready), 32'h1);
            chk("idle_recv", 32'(sram_receive_valid), 32'h0);
         end else begin
            kk = cyc - acc + 1;
            chk("ren", 32'(sram_ren),
                32'((c_ld && !c_err) && kk == 1));
            chk("wen", 32'(sram_wen), 32'((c_st && !c_err) && kk == 1));
            chk("wmask", 32'(sram_wmask),
                (c_st && !c_err && kk == 1) ? 32'(c_mask) : 32'h0);
            chk("recv", 32'(sram_receive_valid),
                32'(c_ld && !c_err && !c_to && kk == 2));
            chk("resp_valid", 32'(resp_valid), 32'(kk >= c_l));
            chk("req_ready", 32'(req_ready), 32'h0);
            if (kk >= c_l) begin
               chk("resp_rdata", resp_rdata, c_rdata);
               chk("resp_err", 32'(resp_err), 32'(c_err || c_to));
            end
            if (!c_err && kk < c_l)
               chk("sram_addr", sram_addr, c_addr & 32'hFFFF_FFFC);
            if (c_st && !c_err && kk == 1)
               chk("sram_wdata", sram_wdata, c_wd);
         end
      end
   end

   task automatic run(input vec_t v);
      bit e;
      int l;
      e = m_err(v.ld, v.st, v.f3, v.addr);
      l = e ? 1 : v.st ? 2 : v.to ? 2 + TIMEOUT : 3;
      c_ld    = v.ld;
      c_st    = v.st;
      c_to    = v.to && !e;
      c_err   = e;
      c_l     = l;
      c_d     = v.d;
      c_addr  = v.addr;
      c_rdata = (e || v.st || v.to) ? 32'h0 : m_rdata(v.f3, v.addr, v.sdata);
      c_mask  = m_mask(v.f3, v.addr);
      c_wd    = v.wdata << (8 * (v.addr % 4));
      chk("model_rdata", c_rdata, v.er);
      chk("model_err", 32'(e || v.to), 32'(v.ee));
      if (v.st && !e) begin
         chk("model_mask", 32'(c_mask), 32'(v.em));
         chk("model_wdata", c_wd, v.ew);
      end
      req_valid  = 1'b1;
      req_load   = v.ld;
      req_store  = v.st;
      req_funct3 = v.f3;
      req_addr   = v.addr;
      req_wdata  = v.wdata;
      @(posedge clk);
      #1;
      acc    = cyc;
      active = 1'b1;
      for (int k = 1; k <= l + v.d; k++) begin
         req_valid  = (v.d > 0) && (k < l + v.d);
         req_addr   = 32'h8000_0100;
         req_funct3 = 3'b010;
         sram_valid = (v.ld && !e && !v.to && k == 2) ||
                      (v.st && !e && k == 1);
         sram_data  = (k == 2) ? v.sdata : 32'h5A5A_5A5A;
         resp_ready = (k == l + v.d);
         if (k == l) begin
            chk("lit_rdata", resp_rdata, v.er);
            chk("lit_err", 32'(resp_err), 32'(v.ee));
         end
         @(posedge clk);
         #1;
      end
      active     = 1'b0;
      req_valid  = 1'b0;
      resp_ready = 1'b0;
      sram_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      vq.push_back('{1,0,3'b010,32'h8000_0004,0,32'hDEAD_BEEF,0,0,32'hDEAD_BEEF,0,0,0});
      vq.push_back('{1,0,3'b000,32'h8000_0003,0,32'h80FF_1122,0,0,32'hFFFF_FF80,0,0,0});
      vq.push_back('{1,0,3'b100,32'h8000_0003,0,32'h80FF_1122,0,0,32'h0000_0080,0,0,0});
      vq.push_back('{0,1,3'b001,32'h8000_0002,32'h0000_ABCD,0,0,0,0,0,8'h0C,32'hABCD_0000});
      vq.push_back('{1,0,3'b001,32'h8000_0001,0,32'h1234_5678,0,0,0,1,0,0});
      vq.push_back('{1,0,3'b010,32'h8000_0010,0,32'h1234_5678,0,5,32'h1234_5678,0,0,0});
      vq.push_back('{0,1,3'b000,32'h8000_0001,32'h0000_00A5,0,0,0,0,0,8'h02,32'h0000_A500});
      vq.push_back('{0,1,3'b010,32'h8000_0008,32'hCAFE_F00D,0,0,3,0,0,8'h0F,32'hCAFE_F00D});
      vq.push_back('{1,0,3'b101,32'h8000_0002,0,32'h8001_F00F,0,0,32'h0000_8001,0,0,0});
      vq.push_back('{1,0,3'b001,32'h8000_0002,0,32'h8001_F00F,0,0,32'hFFFF_8001,0,0,0});
      vq.push_back('{1,0,3'b000,32'h8000_0000,0,32'h0000_007F,0,0,32'h0000_007F,0,0,0});
      vq.push_back('{0,1,3'b000,32'h8000_0003,32'h0000_0011,0,0,0,0,0,8'h08,32'h1100_0000});
      vq.push_back('{1,1,3'b010,32'h8000_0000,0,0,0,0,0,1,0,0});
      vq.push_back('{0,0,3'b010,32'h8000_0000,0,0,0,3,0,1,0,0});
      vq.push_back('{1,0,3'b011,32'h8000_0000,0,0,0,0,0,1,0,0});
      vq.push_back('{1,0,3'b110,32'h8000_0000,0,0,0,0,0,1,0,0});
      vq.push_back('{0,1,3'b100,32'h8000_0000,0,0,0,0,0,1,0,0});
      vq.push_back('{0,1,3'b010,32'h8000_0002,32'h1,0,0,0,0,1,0,0});
      vq.push_back('{1,0,3'b010,32'h8000_0001,0,0,0,0,0,1,0,0});
      vq.push_back('{1,0,3'b010,32'h8000_0020,0,32'h1111_1111,1,0,0,1,0,0});
      vq.push_back('{1,0,3'b010,32'h8000_0024,0,32'h0BAD_CAFE,0,2,32'h0BAD_CAFE,0,0,0});

      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ren", 32'(sram_ren), 32'h0);
      chk("rst_wen", 32'(sram_wen), 32'h0);
      chk("rst_wmask", 32'(sram_wmask), 32'h0);
      chk("rst_addr", sram_addr, 32'h0);
      chk("rst_wdata", sram_wdata, 32'h0);
      chk("rst_resp_valid", 32'(resp_valid), 32'h0);
      chk("rst_rdata", resp_rdata, 32'h0);
      chk("rst_err", 32'(resp_err), 32'h0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk_en = 1'b1;

      foreach (vq[i]) run(vq[i]);

      chk_en     = 1'b0;
      req_valid  = 1'b1;
      req_load   = 1'b1;
      req_store  = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = 32'h8000_0040;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      chk("mrst_req_ready", 32'(req_ready), 32'h1);
      chk("mrst_ren", 32'(sram_ren), 32'h0);
      chk("mrst_wen", 32'(sram_wen), 32'h0);
      chk("mrst_recv", 32'(sram_receive_valid), 32'h0);
      chk("mrst_resp_valid", 32'(resp_valid), 32'h0);
      chk("mrst_err", 32'(resp_err), 32'h0);
      chk("mrst_addr", sram_addr, 32'h0);
      @(posedge clk);
      #1;
      chk("mrst_ren_next", 32'(sram_ren), 32'h0);
      chk("mrst_wen_next", 32'(sram_wen), 32'h0);
      chk("mrst_resp_next", 32'(resp_valid), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
